// File: rtl/uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter: FSM encoding, status bit positions
// and the bus addresses used by the top-level decoder.
package uart_pkg;

    typedef logic [1:0] tx_state_t;

    localparam tx_state_t ST_IDLE  = 2'd0;
    localparam tx_state_t ST_START = 2'd1;
    localparam tx_state_t ST_DATA  = 2'd2;
    localparam tx_state_t ST_STOP  = 2'd3;

    localparam int unsigned STAT_FULL       = 0;
    localparam int unsigned STAT_EMPTY      = 1;
    localparam int unsigned STAT_BUSY       = 2;
    localparam int unsigned STAT_OVF        = 3;
    localparam int unsigned STAT_FRAME_DONE = 12;

    localparam logic [31:0] UART_DATA_ADR = 32'hff10;
    localparam logic [31:0] UART_STAT_ADR = 32'hff14;

endpackage

// File: rtl/uart_tx_fifo.sv
// DEPTH x 8 synchronous FIFO for the UART transmitter. A push into a full FIFO is accepted
// only when a pop happens in the same cycle; otherwise it is dropped and drop_o flags it.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [7:0]    wdata_i,
    output logic [7:0]    rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          drop_o,
    output logic [CW-1:0] count_o
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign drop_o  = push_i & ~do_push;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointers wrap on their own because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO and a drain interrupt.
// Define UART_TX_LOOPBACK_EN to add the rxd_loop output and the frame_done status bit.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int unsigned DIV   = 543,
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_data,
    input  logic        cs_stat,
    input  logic        memwrite,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        txd,
    output logic        irq
`ifdef UART_TX_LOOPBACK_EN
    ,
    output logic        rxd_loop
`endif
);

    localparam int unsigned CW        = $clog2(DEPTH) + 1;
    localparam logic [15:0] BAUD_LAST = 16'(DIV - 1);

    tx_state_t     state_q, state_d;
    logic [15:0]   baud_q, baud_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          txd_q, txd_d;
    logic          irq_q, irq_d;
    logic          ovf_q, ovf_d;

    logic          push, stat_wr, bit_done;
    logic          fifo_pop, fifo_full, fifo_empty, fifo_drop;
    logic [7:0]    fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic          unused_wdata;

    assign push     = cs_data & memwrite;
    assign stat_wr  = cs_stat & memwrite;
    assign bit_done = (baud_q == BAUD_LAST);
    assign unused_wdata = ^writedata[31:8];

    uart_tx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (push),
        .pop_i   (fifo_pop),
        .wdata_i (writedata[7:0]),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .drop_o  (fifo_drop),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        txd_d     = txd_q;
        irq_d     = 1'b0;
        fifo_pop  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_rdata;
                    state_d  = ST_START;
                    txd_d    = 1'b0;
                    baud_d   = '0;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d   = ST_DATA;
                    txd_d     = shreg_q[0];
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = '0;
                    baud_d    = '0;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    baud_d = '0;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        txd_d     = shreg_q[0];
                        shreg_d   = shreg_q >> 1;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    baud_d = '0;
                    // Back-to-back frames: the next start bit follows the stop bit directly.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shreg_d  = fifo_rdata;
                        state_d  = ST_START;
                        txd_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        irq_d   = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
        endcase
    end

    // An overflow in the same cycle as a clear wins.
    always_comb begin
        ovf_d = ovf_q;
        if (stat_wr && writedata[STAT_OVF]) ovf_d = 1'b0;
        if (fifo_drop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            txd_q     <= 1'b1;
            irq_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            txd_q     <= txd_d;
            irq_q     <= irq_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef UART_TX_LOOPBACK_EN
    logic frame_done_q, frame_done_d;

    always_comb begin
        frame_done_d = frame_done_q;
        if (stat_wr && writedata[STAT_FRAME_DONE]) frame_done_d = 1'b0;
        if (state_q == ST_STOP && bit_done) frame_done_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= frame_done_d;
        end
    end

    assign rxd_loop = txd_q;
`endif

    always_comb begin
        readdata             = '0;
        readdata[11:4]       = 8'(fifo_count);
        readdata[STAT_FULL]  = fifo_full;
        readdata[STAT_EMPTY] = fifo_empty;
        readdata[STAT_BUSY]  = (state_q != ST_IDLE);
        readdata[STAT_OVF]   = ovf_q;
`ifdef UART_TX_LOOPBACK_EN
        readdata[STAT_FRAME_DONE] = frame_done_q;
`endif
    end

    assign txd = txd_q;
    assign irq = irq_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: directed bus writes feed a byte scoreboard that a UART receiver
// process drains; status, irq and bit timing are checked against hand-computed values.
module tb_uart_tx_mmio;
    import uart_pkg::*;

    localparam int unsigned DIV   = 4;
    localparam int unsigned DEPTH = 8;
`ifdef UART_TX_LOOPBACK_EN
    localparam logic [31:0] RD_MASK = 32'hffff_efff;
`else
    localparam logic [31:0] RD_MASK = 32'hffff_ffff;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cs_data = 1'b0;
    logic        cs_stat = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        txd;
    logic        irq;
`ifdef UART_TX_LOOPBACK_EN
    logic        rxd_loop;
`endif

    always #5 clk = ~clk;

    uart_tx_mmio #(
        .DIV   (DIV),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cs_data   (cs_data),
        .cs_stat   (cs_stat),
        .memwrite  (memwrite),
        .writedata (writedata),
        .readdata  (readdata),
        .txd       (txd),
`ifdef UART_TX_LOOPBACK_EN
        .rxd_loop  (rxd_loop),
`endif
        .irq       (irq)
    );

    int         n_checks = 0;
    int         n_fail = 0;
    int         edge_n = 0;
    int         irq_cnt = 0;
    logic [7:0] exp_q[$];

    always @(posedge clk) edge_n <= edge_n + 1;
    always @(posedge clk) if (irq === 1'b1) irq_cnt <= irq_cnt + 1;

`ifdef UART_TX_LOOPBACK_EN
    int loop_errs = 0;
    always @(negedge clk) if (rxd_loop !== txd) loop_errs <= loop_errs + 1;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] status();
        return readdata & RD_MASK;
    endfunction

    // Line level of a frame in bit slot idx: start, 8 data bits LSB first, stop.
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        return 1'b1;
    endfunction

    task automatic bus_wr(input bit is_data, input logic [31:0] d);
        @(negedge clk);
        cs_data   = is_data;
        cs_stat   = !is_data;
        memwrite  = 1'b1;
        writedata = d;
        @(posedge clk);
        #1;
        cs_data   = 1'b0;
        cs_stat   = 1'b0;
        memwrite  = 1'b0;
        writedata = '0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((readdata[STAT_BUSY] !== 1'b0 || readdata[STAT_EMPTY] !== 1'b1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, n < budget, 1'b1);
        repeat (2) @(negedge clk);
    endtask

    // Receiver: samples mid-bit and pops the expected byte at each completed frame.
    initial begin : monitor
        logic [7:0] b;
        bit         abort;
        int         qs;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && txd === 1'b0) begin
                abort = 1'b0;
                b     = '0;
                for (int t = 1; t <= int'(9 * DIV + DIV / 2); t++) begin
                    @(negedge clk);
                    if (reset !== 1'b1) begin
                        abort = 1'b1;
                        break;
                    end
                    if (t % int'(DIV) == int'(DIV / 2)) begin
                        if (t / int'(DIV) == 0) check("mon_start_bit", txd, 1'b0);
                        else if (t / int'(DIV) <= 8) b[t/int'(DIV)-1] = txd;
                        else check("mon_stop_bit", txd, 1'b1);
                    end
                end
                if (!abort) begin
                    qs = exp_q.size();
                    check("mon_frame_expected", qs != 0, 1'b1);
                    if (qs != 0) check("mon_frame_byte", b, exp_q.pop_front());
                end
            end
        end
    end

    initial begin : stim
        int k, ic0, errs;

        repeat (3) @(negedge clk);
        check("rst_txd", txd, 1'b1);
        check("rst_irq", irq, 1'b0);
        check("rst_status", status(), 32'h2);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single frame: exact waveform and irq timing.
        ic0 = irq_cnt;
        bus_wr(1'b1, 32'h55);
        exp_q.push_back(8'h55);
        @(negedge clk);
        check("t1_txd_at_k", txd, 1'b1);
        check("t1_status_count1", status(), 32'h10);
        errs = 0;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (txd !== frame_bit(8'h55, (j - 1) / int'(DIV)) || irq !== 1'b0 ||
                readdata[STAT_BUSY] !== 1'b1) errs++;
        end
        check("t1_waveform_errs", errs, 0);
        @(negedge clk);
        check("t1_irq_k41", irq, 1'b1);
        check("t1_idle_k41", status(), 32'h2);
        @(negedge clk);
        check("t1_irq_k42", irq, 1'b0);
        check("t1_irq_pulses", irq_cnt - ic0, 1);

        // Nine back-to-back frames, a dropped tenth byte, overflow clear.
        repeat (3) @(negedge clk);
        ic0 = irq_cnt;
        k   = 0;
        for (int i = 0; i < 9; i++) begin
            bus_wr(1'b1, 32'(i));
            if (i == 0) k = edge_n;
            exp_q.push_back(8'(i));
        end
        bus_wr(1'b1, 32'h09);
        @(negedge clk);
        check("t2_full_ovf", status(), 32'h8d);
        bus_wr(1'b0, 32'h8);
        @(negedge clk);
        check("t2_ovf_cleared", status(), 32'h85);
        errs = 0;
        forever begin
            @(negedge clk);
            if (edge_n - k >= 361) break;
            if (readdata[STAT_BUSY] !== 1'b1 || irq !== 1'b0) errs++;
        end
        check("t2_no_gap_errs", errs, 0);
        check("t2_irq_k361", irq, 1'b1);
        check("t2_idle_k361", status(), 32'h2);
        @(negedge clk);
        check("t2_single_irq", irq_cnt - ic0, 1);

        // Status while busy with two bytes queued.
        repeat (2) @(negedge clk);
        bus_wr(1'b1, 32'ha1);
        bus_wr(1'b1, 32'hb2);
        bus_wr(1'b1, 32'hc3);
        exp_q.push_back(8'ha1);
        exp_q.push_back(8'hb2);
        exp_q.push_back(8'hc3);
        @(negedge clk);
        check("t3_status", status(), 32'h24);
        bus_wr(1'b0, 32'h8);
        @(negedge clk);
        check("t3_status_after_clr", status(), 32'h24);
        wait_idle(200, "t3_drain");

        // Push into a full FIFO on the STOP->START pop edge.
        for (int i = 0; i < 9; i++) begin
            bus_wr(1'b1, 32'hd0 + 32'(i));
            if (i == 0) k = edge_n;
            exp_q.push_back(8'hd0 + 8'(i));
        end
        while (edge_n - k < 39) @(negedge clk);
        check("t4_full_before", status(), 32'h85);
        bus_wr(1'b1, 32'hee);
        exp_q.push_back(8'hee);
        @(negedge clk);
        check("t4_accept_on_pop", status(), 32'h85);
        wait_idle(600, "t4_drain");

        // Reset in the middle of data bit 3 of 0xA5.
        ic0 = irq_cnt;
        bus_wr(1'b1, 32'ha5);
        k = edge_n;
        bus_wr(1'b1, 32'h11);
        bus_wr(1'b1, 32'h22);
        while (edge_n - k < 18) @(negedge clk);
        check("t5_bit3_level", txd, 1'b0);
        #1;
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("t5_txd_on_reset", txd, 1'b1);
        check("t5_status_in_reset", status(), 32'h2);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        errs = 0;
        repeat (100) begin
            @(negedge clk);
            if (txd !== 1'b1 || irq !== 1'b0 || status() !== 32'h2) errs++;
        end
        check("t5_quiet_after_reset", errs, 0);
        check("t5_no_irq", irq_cnt - ic0, 0);

`ifdef UART_TX_LOOPBACK_EN
        bus_wr(1'b1, 32'h3c);
        exp_q.push_back(8'h3c);
        @(negedge clk);
        check("lb_frame_done_clear_start", readdata[STAT_FRAME_DONE], 1'b0);
        wait_idle(100, "lb_drain");
        check("lb_frame_done_set", readdata[STAT_FRAME_DONE], 1'b1);
        bus_wr(1'b0, 32'h1000);
        @(negedge clk);
        check("lb_frame_done_cleared", readdata[STAT_FRAME_DONE], 1'b0);
        check("lb_mirror_errs", loop_errs, 0);
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_checks);
        $fatal(1, "timeout");
    end

endmodule
